// File: rtl/fft_pkg.sv
// Shared constants, read FSM encoding and bit-reversal helper
// for the FFT input reorder stage.
package fft_pkg;

   localparam int WIDTH = 32;
   localparam int N     = 16;
   localparam int LOG2N = 4;

   typedef enum logic {
      IDLE = 1'b0,
      READ = 1'b1
   } rd_state_t;

   // Reverse the low 'bits' bits of k; higher bits come out zero.
   function automatic logic [LOG2N-1:0] bitrev(
      input logic [LOG2N-1:0] k,
      input int               bits
   );
      logic [LOG2N-1:0] r;
      r = '0;
      for (int i = 0; i < LOG2N; i++) begin
         if (i < bits) r[i] = k[bits-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_input_bitrev_if.sv
// Sample streams in and out of the reorder stage.
// The slave side is the reorder block, master is its environment.
interface fft_input_bitrev_if #(
   parameter int WIDTH = 32
);

   logic                    input_en;
   logic signed [WIDTH-1:0] input_real;
   logic signed [WIDTH-1:0] input_imag;
   logic                    output_en;
   logic signed [WIDTH-1:0] output_real;
   logic signed [WIDTH-1:0] output_imag;
   logic                    output_first;

   modport master (
      output input_en,
      output input_real,
      output input_imag,
      input  output_en,
      input  output_real,
      input  output_imag,
      input  output_first
   );

   modport slave (
      input  input_en,
      input  input_real,
      input  input_imag,
      output output_en,
      output output_real,
      output output_imag,
      output output_first
   );

endinterface

// File: rtl/fft_pingpong_ram.sv
// Two-bank sample store: synchronous write, asynchronous read,
// addressed by {bank, addr}. Contents are never reset.
module fft_pingpong_ram #(
   parameter int WIDTH = 32,
   parameter int N     = 16,
   parameter int LOG2N = 4
) (
   input  logic               clock,
   input  logic               we,
   input  logic [LOG2N:0]     wr_addr,
   input  logic [2*WIDTH-1:0] wr_data,
   input  logic [LOG2N:0]     rd_addr,
   output logic [2*WIDTH-1:0] rd_data
);

   logic [2*WIDTH-1:0] mem [2*N];

   // Store one packed {real, imag} sample per enabled edge.
   always_ff @(posedge clock) begin
      if (we) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fft_input_bitrev.sv
// Natural-order to bit-reversed-order frame reorder ahead of
// the SDF FFT; ping-pong banks, output frames never stall.
module fft_input_bitrev #(
   parameter int WIDTH = fft_pkg::WIDTH,
   parameter int N     = fft_pkg::N,
   parameter int LOG2N = fft_pkg::LOG2N
) (
   input logic               clock,
   input logic               reset,
   fft_input_bitrev_if.slave bus
);

   import fft_pkg::rd_state_t;
   import fft_pkg::IDLE;
   import fft_pkg::READ;
   import fft_pkg::bitrev;

   logic [LOG2N-1:0]   wr_cnt;
   logic [LOG2N-1:0]   rd_cnt;
   logic               wr_bank;
   logic               rd_bank;
   logic [1:0]         full;
   logic [1:0]         full_set;
   logic [1:0]         full_clr;
   logic               wr_done;
   logic               rd_last;
   logic [2*WIDTH-1:0] rd_data;
   rd_state_t          state;

   assign wr_done = bus.input_en
                 && (wr_cnt == LOG2N'(N - 1));
   assign rd_last = (state == READ)
                 && (rd_cnt == LOG2N'(N - 1));

   assign full_set = wr_done ? (2'b01 << wr_bank) : 2'b00;
   assign full_clr = rd_last ? (2'b01 << rd_bank) : 2'b00;

   fft_pingpong_ram #(
      .WIDTH (WIDTH),
      .N     (N),
      .LOG2N (LOG2N)
   ) u_ram (
      .clock   (clock),
      .we      (bus.input_en),
      .wr_addr ({wr_bank, wr_cnt}),
      .wr_data ({bus.input_real, bus.input_imag}),
      .rd_addr ({rd_bank, bitrev(rd_cnt, LOG2N)}),
      .rd_data (rd_data)
   );

   // Write pointer: fill the current bank, flip on the last sample.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_cnt  <= '0;
         wr_bank <= 1'b0;
      end else if (bus.input_en) begin
         if (wr_done) begin
            wr_cnt  <= '0;
            wr_bank <= ~wr_bank;
         end else begin
            wr_cnt <= wr_cnt + 1'b1;
         end
      end
   end

   // Bank-full flags: set by a completed fill, cleared by a drain.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) full <= '0;
      else       full <= (full & ~full_clr) | full_set;
   end

   // Read FSM: drain a full bank as one unbroken 16-cycle burst.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         rd_cnt           <= '0;
         rd_bank          <= 1'b0;
         bus.output_en    <= 1'b0;
         bus.output_first <= 1'b0;
         bus.output_real  <= '0;
         bus.output_imag  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               bus.output_en    <= 1'b0;
               bus.output_first <= 1'b0;
               if (full[rd_bank]) begin
                  state  <= READ;
                  rd_cnt <= '0;
               end
            end
            READ: begin
               bus.output_en    <= 1'b1;
               bus.output_first <= (rd_cnt == '0);
               bus.output_real  <= $signed(rd_data[2*WIDTH-1:WIDTH]);
               bus.output_imag  <= $signed(rd_data[WIDTH-1:0]);
               if (rd_last) begin
                  rd_cnt  <= '0;
                  rd_bank <= ~rd_bank;
                  state   <= full[~rd_bank] ? READ : IDLE;
               end else begin
                  rd_cnt <= rd_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/fft_input_bitrev.md
Name: fft_input_bitrev

Overview:
- Upstream input-reorder stage for the 16-point radix-2 SDF FFT (fft_16_top).
- Accepts complex samples in natural time order and emits each 16-sample frame in bit-reversed index order. The FFT consumes that order.
- Ping-pong buffer: one bank fills while the other drains.
- Output frames are always 16 contiguous cycles, because the SDF pipeline cannot stall.

Parameters:
- WIDTH, 32, bit width of each of the real and imaginary sample components (signed).
- N, 16, frame length in samples; must be a power of two.
- LOG2N, 4, log2(N); width of the address counters.

Ports:
- clock, input, 1, single clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-high; clears all control state and output registers.
- input_en, input, 1, high means input_real/input_imag hold a valid sample this cycle.
- input_real, input, WIDTH, signed real part, natural order.
- input_imag, input, WIDTH, signed imaginary part, natural order.
- output_en, output, 1, high means output_real/output_imag are valid; connects to fft_16_top input_en.
- output_real, output, WIDTH, signed real part, bit-reversed order.
- output_imag, output, WIDTH, signed imaginary part, bit-reversed order.
- output_first, output, 1, high with output_en on the first sample (index 0) of each output frame.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - output_en, output_first, output_real and output_imag go to 0.
  - Write counter wr_cnt=0, wr_bank=0, rd_cnt=0, rd_bank=0, full[1:0]=0, FSM goes to IDLE.
  - Memory contents are not reset. A partial frame is discarded.
- Write side, on each edge with input_en=1:
  - mem[wr_bank][wr_cnt] <= sample, and wr_cnt increments.
  - When wr_cnt==N-1: wr_cnt<=0, full[wr_bank]<=1, wr_bank toggles.
  - input_en=0 pauses writing. Gaps of any length are allowed and no timeout applies.
- Read FSM has two states, IDLE and READ.
  - IDLE: if full[rd_bank]=1, go to READ with rd_cnt=0. No output this edge.
  - READ, each edge:
    - output_real/imag <= mem[rd_bank][bitrev(rd_cnt)], output_en<=1, output_first<=(rd_cnt==0), rd_cnt increments.
    - When rd_cnt==N-1: full[rd_bank]<=0, rd_bank toggles, rd_cnt<=0.
    - Then stay in READ if full[other bank]=1, otherwise go to IDLE.
  - Leaving READ: the next edge drives output_en=0 and output_first=0. output_real/imag hold their last value.
- bitrev(k) reverses the LOG2N bits of k. For N=16 the read address sequence is 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.
- Latency:
  - Last input sample of a frame sampled at edge k.
  - First reordered sample is registered at edge k+2.
  - output_en is high from after edge k+2 through edge k+17, i.e. exactly N cycles.
- Back-to-back frames: with contiguous input, the next frame completes at edge k+16 and its output continues seamlessly. output_en stays high with no gap between frames.
- Bank safety:
  - Write rate is at most the read rate, so the writer never enters a bank before its read completes.
  - At edge k+17, write address 0 and the final read address 15 of the same bank coincide legally.
- Data passes through unmodified, bit-exact, with no scaling or saturation.

Decomposition:
- Shared package fft_pkg holds:
  - Constants WIDTH, N, LOG2N.
  - Function bitrev(k, LOG2N).
  - FSM state encoding (IDLE=0, READ=1).
- One sub-module: fft_pingpong_ram. It is a 2xN-entry, 2*WIDTH-wide memory with one synchronous write port and one asynchronous read port, addressed by {bank, addr}.

Test Plan:
- Single frame, contiguous: input_en high for 16 edges, real=n+1, imag=-(n+1) for n=0..15 -> output_en high 16 cycles starting 2 edges after the last input. Real sequence 1,9,5,13,3,11,7,15,2,10,6,14,4,12,8,16; imag is its negation; output_first only on the first cycle.
- Back-to-back frames: 32 contiguous inputs, frame 2 real=101..116 -> 32 consecutive output_en cycles. Second frame is 101,109,105,113,...,108,116. output_first is high on cycles 0 and 16 of the burst.
- Gapped input: input_en alternating 1/0 over 32 cycles, real=n+1 -> output is still one contiguous 16-cycle burst with the same bit-reversed sequence. Nothing is output before the 16th sample.
- Reset mid-fill: after 7 samples, pulse reset; then feed a full frame real=201..216 -> output is 201,209,205,...,216 with no stale samples.
- Reset mid-drain: assert reset during output cycle 5 -> output_en, output_real and output_imag read 0 immediately, before the next clock edge. No further output occurs without a new full frame.
- Extremes: real=-2^31, imag=2^31-1 at index 0 and their swap at index 15 -> values reappear bit-exact at output positions 0 and 15.
